// File: rtl/player_input_tracker_pkg.sv
// Shared constants, decoder state encoding and key-map lookup for the PS/2 player input tracker.
package player_input_tracker_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // P1 keys arrive E0-extended, P2 keys are plain codes.
    localparam logic [7:0] KEY_P1_UP    = 8'h75;
    localparam logic [7:0] KEY_P1_DOWN  = 8'h72;
    localparam logic [7:0] KEY_P1_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_P1_RIGHT = 8'h74;
    localparam logic [7:0] KEY_P1_FIRE  = 8'h5A;
    localparam logic [7:0] KEY_P2_UP    = 8'h1D;
    localparam logic [7:0] KEY_P2_DOWN  = 8'h1B;
    localparam logic [7:0] KEY_P2_LEFT  = 8'h1C;
    localparam logic [7:0] KEY_P2_RIGHT = 8'h23;
    localparam logic [7:0] KEY_P2_FIRE  = 8'h29;

    localparam int unsigned CMD_UP    = 0;
    localparam int unsigned CMD_DOWN  = 1;
    localparam int unsigned CMD_LEFT  = 2;
    localparam int unsigned CMD_RIGHT = 3;
    localparam int unsigned CMD_FIRE  = 4;
    localparam int unsigned CMD_W     = 5;
    localparam int unsigned NUM_KEYS  = 10;
    localparam int unsigned P2_BASE   = 5;

    typedef enum logic [2:0] {
        StIdle,
        StBrk,
        StExt,
        StExtBrk,
        StSkip
    } dec_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code, input logic ext);
        key_map_t m;
        m.hit = 1'b1;
        m.idx = '0;
        if (ext) begin
            case (code)
                KEY_P1_UP:    m.idx = 4'(CMD_UP);
                KEY_P1_DOWN:  m.idx = 4'(CMD_DOWN);
                KEY_P1_LEFT:  m.idx = 4'(CMD_LEFT);
                KEY_P1_RIGHT: m.idx = 4'(CMD_RIGHT);
                KEY_P1_FIRE:  m.idx = 4'(CMD_FIRE);
                default:      m.hit = 1'b0;
            endcase
        end else begin
            case (code)
                KEY_P2_UP:    m.idx = 4'(P2_BASE + CMD_UP);
                KEY_P2_DOWN:  m.idx = 4'(P2_BASE + CMD_DOWN);
                KEY_P2_LEFT:  m.idx = 4'(P2_BASE + CMD_LEFT);
                KEY_P2_RIGHT: m.idx = 4'(P2_BASE + CMD_RIGHT);
                KEY_P2_FIRE:  m.idx = 4'(P2_BASE + CMD_FIRE);
                default:      m.hit = 1'b0;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/player_input_tracker_if.sv
// Scan-code input, frame strobe and per-player command outputs of the input tracker.
interface player_input_tracker_if;
    import player_input_tracker_pkg::*;

    logic [7:0]          scan_code;
    logic                scan_code_ready;
    logic                frame_tick;
    logic [NUM_KEYS-1:0] key_held;
    logic [CMD_W-1:0]    p1_cmd;
    logic [CMD_W-1:0]    p2_cmd;
    logic                p1_fire_pulse;
    logic                p2_fire_pulse;
    logic                seq_error;

    modport master (
        output scan_code, scan_code_ready, frame_tick,
        input  key_held, p1_cmd, p2_cmd, p1_fire_pulse, p2_fire_pulse, seq_error
    );

    modport slave (
        input  scan_code, scan_code_ready, frame_tick,
        output key_held, p1_cmd, p2_cmd, p1_fire_pulse, p2_fire_pulse, seq_error
    );

endinterface

// File: rtl/player_input_tracker_cmd_frame_latch.sv
// Per-player frame latch: cancels opposing directions, latches the command word on each
// frame tick and flags the tick on which fire first becomes held.
module cmd_frame_latch
    import player_input_tracker_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_frame_tick,
    input  logic [CMD_W-1:0] i_held,
    output logic [CMD_W-1:0] o_cmd,
    output logic             o_fire_pulse
);

    logic [CMD_W-1:0] r_cmd;
    logic [CMD_W-1:0] w_sane;
    logic             r_prev_fire;
    logic             r_fire_pulse;

    always_comb begin
        w_sane = i_held;
        if (i_held[CMD_UP] && i_held[CMD_DOWN]) begin
            w_sane[CMD_UP]   = 1'b0;
            w_sane[CMD_DOWN] = 1'b0;
        end
        if (i_held[CMD_LEFT] && i_held[CMD_RIGHT]) begin
            w_sane[CMD_LEFT]  = 1'b0;
            w_sane[CMD_RIGHT] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmd        <= '0;
            r_prev_fire  <= 1'b0;
            r_fire_pulse <= 1'b0;
        end else begin
            r_fire_pulse <= 1'b0;
            if (i_frame_tick) begin
                r_cmd        <= w_sane;
                r_fire_pulse <= i_held[CMD_FIRE] & ~r_prev_fire;
                r_prev_fire  <= i_held[CMD_FIRE];
            end
        end
    end

    assign o_cmd        = r_cmd;
    assign o_fire_pulse = r_fire_pulse;

endmodule

// File: rtl/player_input_tracker.sv
// PS/2 scan-code decoder tracking held direction/fire keys for two players, with prefix
// timeout recovery and per-frame command latching.
module player_input_tracker
    import player_input_tracker_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 2_500_000,
    parameter int unsigned PAUSE_SKIP     = 7
) (
    input logic                  clk,
    input logic                  reset,
    player_input_tracker_if.slave bus
);

    localparam int unsigned TMO_W  = $clog2(PREFIX_TIMEOUT);
    localparam int unsigned SKIP_W = $clog2(PAUSE_SKIP + 1);

    dec_state_e          r_state, w_state_next;
    logic [TMO_W-1:0]    r_tmo_cnt, w_tmo_next;
    logic [SKIP_W-1:0]   r_skip_cnt, w_skip_next;
    logic [NUM_KEYS-1:0] r_key_held, w_held_next;
    logic                r_seq_error, w_seq_error;
    key_map_t            w_map;
    logic                w_is_prefix;
    logic [CMD_W-1:0]    w_p1_cmd, w_p2_cmd;
    logic                w_p1_fire_pulse, w_p2_fire_pulse;

    assign w_map = map_key(bus.scan_code, (r_state == StExt) || (r_state == StExtBrk));
    assign w_is_prefix = (bus.scan_code == PS2_BREAK) || (bus.scan_code == PS2_EXT);

    always_comb begin
        w_state_next = r_state;
        w_tmo_next   = r_tmo_cnt;
        w_skip_next  = r_skip_cnt;
        w_held_next  = r_key_held;
        w_seq_error  = 1'b0;
        if (bus.scan_code_ready) begin
            w_tmo_next = '0;
            case (r_state)
                StIdle: begin
                    if (bus.scan_code == PS2_BREAK) begin
                        w_state_next = StBrk;
                    end else if (bus.scan_code == PS2_EXT) begin
                        w_state_next = StExt;
                    end else if (bus.scan_code == PS2_PAUSE) begin
                        w_state_next = StSkip;
                        w_skip_next  = SKIP_W'(PAUSE_SKIP);
                    end else if (w_map.hit) begin
                        w_held_next[w_map.idx] = 1'b1;
                    end
                end
                StExt: begin
                    if (bus.scan_code == PS2_BREAK) begin
                        w_state_next = StExtBrk;
                    end else if (bus.scan_code != PS2_EXT) begin
                        w_state_next = StIdle;
                        if (w_map.hit) begin
                            w_held_next[w_map.idx] = 1'b1;
                        end
                    end
                end
                StBrk, StExtBrk: begin
                    // A second prefix after a break means the byte stream is corrupt.
                    w_state_next = StIdle;
                    if (w_is_prefix) begin
                        w_seq_error = 1'b1;
                    end else if (w_map.hit) begin
                        w_held_next[w_map.idx] = 1'b0;
                    end
                end
                StSkip: begin
                    w_skip_next = r_skip_cnt - SKIP_W'(1);
                    if (r_skip_cnt <= SKIP_W'(1)) begin
                        w_state_next = StIdle;
                    end
                end
                default: w_state_next = StIdle;
            endcase
        end else if (r_state != StIdle) begin
            if (r_tmo_cnt == TMO_W'(PREFIX_TIMEOUT - 1)) begin
                w_state_next = StIdle;
                w_tmo_next   = '0;
                w_seq_error  = 1'b1;
            end else begin
                w_tmo_next = r_tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_tmo_cnt   <= '0;
            r_skip_cnt  <= '0;
            r_key_held  <= '0;
            r_seq_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tmo_cnt   <= w_tmo_next;
            r_skip_cnt  <= w_skip_next;
            r_key_held  <= w_held_next;
            r_seq_error <= w_seq_error;
        end
    end

    // Latches sample the registered held flags, so a coincident byte lands next frame.
    cmd_frame_latch u_p1_latch (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (bus.frame_tick),
        .i_held       (r_key_held[CMD_W-1:0]),
        .o_cmd        (w_p1_cmd),
        .o_fire_pulse (w_p1_fire_pulse)
    );

    cmd_frame_latch u_p2_latch (
        .clk          (clk),
        .reset        (reset),
        .i_frame_tick (bus.frame_tick),
        .i_held       (r_key_held[P2_BASE +: CMD_W]),
        .o_cmd        (w_p2_cmd),
        .o_fire_pulse (w_p2_fire_pulse)
    );

    assign bus.key_held      = r_key_held;
    assign bus.seq_error     = r_seq_error;
    assign bus.p1_cmd        = w_p1_cmd;
    assign bus.p2_cmd        = w_p2_cmd;
    assign bus.p1_fire_pulse = w_p1_fire_pulse;
    assign bus.p2_fire_pulse = w_p2_fire_pulse;

endmodule

// File: tb/tb_player_input_tracker.sv
// Vector table plus hand sequences for the player input tracker, checked through a queue.
module tb_player_input_tracker;

    localparam int unsigned TMO = 16;

    logic clk = 1'b0;
    logic reset;

    player_input_tracker_if bus();

    player_input_tracker #(
        .PREFIX_TIMEOUT (TMO),
        .PAUSE_SKIP     (7)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] code;
        logic       rdy;
        logic       tick;
        logic [9:0] held;
        logic [4:0] p1;
        logic [4:0] p2;
        logic       fp1;
        logic       fp2;
        logic       err;
    } vec_t;

    vec_t        vecs[$];
    logic [22:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t v(input logic [7:0] code, input logic rdy, input logic tick,
                               input logic [9:0] held, input logic [4:0] p1,
                               input logic [4:0] p2, input logic fp1, input logic fp2,
                               input logic err);
        vec_t r;
        r.code = code; r.rdy = rdy; r.tick = tick; r.held = held;
        r.p1 = p1; r.p2 = p2; r.fp1 = fp1; r.fp2 = fp2; r.err = err;
        return r;
    endfunction

    function automatic logic [22:0] outs();
        return {bus.key_held, bus.p1_cmd, bus.p2_cmd, bus.p1_fire_pulse, bus.p2_fire_pulse,
                bus.seq_error};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic [7:0] code, input logic rdy, input logic tick,
                        input logic [22:0] exp, input string name);
        bus.scan_code       = code;
        bus.scan_code_ready = rdy;
        bus.frame_tick      = tick;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check(name, 32'(outs()), 32'(exp_q.pop_front()));
        bus.scan_code_ready = 1'b0;
        bus.frame_tick      = 1'b0;
    endtask

    initial begin
        int n;
        logic seen;

        // {code, rdy, tick} -> {held, p1, p2, fp1, fp2, err} after the edge
        vecs.push_back(v(8'h1D, 1, 0, 10'h020, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h020, 5'h00, 5'h01, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h020, 5'h00, 5'h01, 0, 0, 0));
        vecs.push_back(v(8'h1D, 1, 0, 10'h000, 5'h00, 5'h01, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h75, 1, 0, 10'h001, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h001, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h72, 1, 0, 10'h003, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h003, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h003, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h003, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h72, 1, 0, 10'h001, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h001, 5'h01, 5'h00, 0, 0, 0));
        // P2 fire: pulse on first tick only
        vecs.push_back(v(8'h29, 1, 0, 10'h201, 5'h01, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h201, 5'h01, 5'h10, 0, 1, 0));
        vecs.push_back(v(8'h00, 0, 0, 10'h201, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h201, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h201, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'h29, 1, 0, 10'h001, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h001, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h001, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'h75, 1, 0, 10'h000, 5'h01, 5'h10, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        // malformed: F0 F0 and E0 F0 E0
        vecs.push_back(v(8'hF0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 1));
        vecs.push_back(v(8'h00, 0, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1D, 1, 0, 10'h020, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h020, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1D, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 1));
        vecs.push_back(v(8'h00, 0, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        // typematic repeat, unmapped codes
        vecs.push_back(v(8'h1C, 1, 0, 10'h080, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1C, 1, 0, 10'h080, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h080, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1C, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1D, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h75, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        // pause sequence is swallowed, then decoder is back in idle
        vecs.push_back(v(8'hE1, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h14, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h77, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE1, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h14, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h77, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1C, 1, 0, 10'h080, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h080, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h1C, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        // byte coincident with tick: latch sees the old held state
        vecs.push_back(v(8'h23, 1, 1, 10'h100, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h100, 5'h00, 5'h08, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h100, 5'h00, 5'h08, 0, 0, 0));
        vecs.push_back(v(8'h23, 1, 0, 10'h000, 5'h00, 5'h08, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        // P1 left+right cancel, fire passes through
        vecs.push_back(v(8'hE0, 1, 0, 10'h000, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h6B, 1, 0, 10'h004, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h004, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h74, 1, 0, 10'h00C, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h00C, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h00C, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h5A, 1, 0, 10'h01C, 5'h00, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h01C, 5'h10, 5'h00, 1, 0, 0));
        vecs.push_back(v(8'h00, 0, 0, 10'h01C, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h01C, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h01C, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h6B, 1, 0, 10'h018, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h018, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h018, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h74, 1, 0, 10'h010, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hE0, 1, 0, 10'h010, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'hF0, 1, 0, 10'h010, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h5A, 1, 0, 10'h000, 5'h10, 5'h00, 0, 0, 0));
        vecs.push_back(v(8'h00, 0, 1, 10'h000, 5'h00, 5'h00, 0, 0, 0));

        bus.scan_code       = 8'h00;
        bus.scan_code_ready = 1'b0;
        bus.frame_tick      = 1'b0;
        reset               = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].code, vecs[i].rdy, vecs[i].tick,
                 {vecs[i].held, vecs[i].p1, vecs[i].p2, vecs[i].fp1, vecs[i].fp2, vecs[i].err},
                 $sformatf("vec%0d", i));
        end

        // Prefix timeout: seq_error must appear exactly TMO cycles after the F0.
        step(8'hF0, 1, 0, 23'd0, "timeout_prefix");
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4 * TMO) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.seq_error) seen = 1'b1;
        end
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_cycles", 32'(n), 32'(TMO));
        step(8'h00, 0, 0, 23'd0, "timeout_pulse_once");
        step(8'h1B, 1, 0, {10'h040, 5'h00, 5'h00, 3'b000}, "timeout_then_make");
        step(8'hF0, 1, 0, {10'h040, 5'h00, 5'h00, 3'b000}, "timeout_rel_prefix");
        step(8'h1B, 1, 0, 23'd0, "timeout_rel");

        // Reset mid-sequence with a frame tick during reset.
        step(8'h1D, 1, 0, {10'h020, 5'h00, 5'h00, 3'b000}, "rst_make");
        step(8'h00, 0, 1, {10'h020, 5'h00, 5'h01, 3'b000}, "rst_tick");
        step(8'hE0, 1, 0, {10'h020, 5'h00, 5'h01, 3'b000}, "rst_ext");
        reset          = 1'b1;
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid", 32'(outs()), 32'd0);
        reset          = 1'b0;
        bus.frame_tick = 1'b0;
        step(8'h75, 1, 0, 23'd0, "after_reset_75");
        step(8'h00, 0, 1, 23'd0, "after_reset_tick");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
